sss_seq_gen: RTL and testbench
==============================

# sss_seq_gen

Sequential, parametrised LTE secondary synchronisation signal generator: on a start request it latches the cell identity (N_ID_1, N_ID_2) and subframe (0 or 5). It derives m0/m1 and streams the 62-element SSS sequence d(0..61) over a valid/ready interface, PAR elements per beat. It sits between the cell-search/config controller and the resource-element mapper, replacing the earlier combinational 62-bit SSS word generator. It adds full 168-cell N_ID_1 support, subframe-5 ordering, back-pressure, abort and input range checking.

## Interface
- PAR, 1: elements per output beat; legal values 1 or 2 (elaboration error otherwise).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request, sampled only when busy=0.
- n_id_1  in  8  N_ID_1, legal range 0..167.
- n_id_2  in  2  N_ID_2, legal range 0..2.
- subframe  in  1  0 = subframe 0, 1 = subframe 5.
- abort  in  1  synchronous cancel of the current sequence.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  PAR  element bits; bit = 1 means −1, bit = 0 means +1. For PAR=2, bit0 = d(2n) and bit1 = d(2n+1).
- out_idx  out  6  index of the first element in the beat (0..61).
- out_last  out  1  final beat of the sequence.
- busy  out  1  a request is latched and in progress.
- done  out  1  one-cycle pulse after the final handshake.
- err  out  1  one-cycle pulse when a start is rejected.

## Operation
- State machine: IDLE → CALC → STREAM → IDLE.
  - IDLE: start=1 with legal inputs latches n_id_1, n_id_2 and subframe, and moves to CALC.
  - IDLE: start=1 with n_id_1>167 or n_id_2=3 pulses err for the next cycle and stays in IDLE.
  - CALC: exactly 1 cycle; registers m0 and m1, then moves to STREAM.
  - STREAM: emits 62/PAR beats, then returns to IDLE.
- m0/m1 derivation, integer division throughout:
  - q' = ⌊N1/30⌋
  - q = ⌊(N1 + q'(q'+1)/2)/30⌋
  - m' = N1 + q(q+1)/2
  - m0 = m' mod 31
  - m1 = (m0 + ⌊m'/31⌋ + 1) mod 31
- Base 31-bit m-sequences, all with initial state x(0..3)=0, x(4)=1, generated as constants at elaboration:
  - x_s: x(i+5) = x(i+2) ⊕ x(i)
  - x_c: x(i+5) = x(i+3) ⊕ x(i)
  - x_z: x(i+5) = x(i+4) ⊕ x(i+2) ⊕ x(i+1) ⊕ x(i)
- Definitions for n = 0..30, all indices mod 31:
  - s0(n) = x_s(n+m0), s1(n) = x_s(n+m1)
  - c0(n) = x_c(n+N2), c1(n) = x_c(n+N2+3)
  - z0(n) = x_z(n + (m0 mod 8)), z1(n) = x_z(n + (m1 mod 8))
- Subframe 0:
  - d(2n) = s0 ⊕ c0
  - d(2n+1) = s1 ⊕ c1 ⊕ z0
- Subframe 5:
  - d(2n) = s1 ⊕ c0
  - d(2n+1) = s0 ⊕ c1 ⊕ z1
- Index pointers are 5-bit modulo-31 counters seeded at m0, m1, N2, N2+3 (mod 31), m0 mod 8 and m1 mod 8. They wrap 30 → 0, not 31 → 0.
- abort=1 in any state: on the next edge go to IDLE, out_valid=0, busy=0, no done. Abort takes priority over a same-cycle handshake.
- start while busy=1 is ignored; there is no err and no effect on the current sequence.

## Timing
- Reset values: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0, err=0, state=IDLE.
- Reset asserted mid-stream clears everything asynchronously; there is no partial output after release.
- start accepted at edge k:
  - busy=1 from k+1.
  - CALC occupies the cycle after k.
  - out_valid=1 with out_idx=0 from edge k+2.
  - Latency is 2 cycles.
- Handshake: a beat transfers when out_valid && out_ready at a rising edge.
- While out_valid=1 && out_ready=0: out_data, out_idx and out_last are held stable.
- With out_ready held at 1: one beat per cycle, no bubbles, 62/PAR consecutive beats.
- Final handshake at edge j:
  - out_valid=0, busy=0 and done=1 during cycle j+1.
  - A start in that cycle is accepted; back-to-back sequences are separated by 2 idle cycles.
- Input changes after acceptance have no effect until the next start.

## Test plan
- N1=0, N2=0, sf=0, PAR=1, out_ready=1:
  - m0=0, m1=1.
  - 62 beats on consecutive cycles, out_idx 0..61, out_last on idx 61, done 1 cycle later.
  - d(0)=0, d(1)=0; full sequence matches the golden model.
- N1=167, N2=2, sf=1 (m0=2, m1=9), PAR=2: 31 beats; out_last on idx 60; all bits match the model with subframe-5 ordering.
- N1=30 (m0=0, m1=2), N2=1, sf=0, random out_ready stalls: data, out_idx and out_last stable during stalls; sequence matches the model.
- start with n_id_1=168, then with n_id_2=3: err pulses for 1 cycle each; busy stays 0; out_valid stays 0.
- abort at beat 20, start during STREAM, and rst_n low mid-stream:
  - abort: out_valid=0 next cycle, no done.
  - start during STREAM: ignored.
  - rst_n low: all outputs 0 immediately.
  - Next start afterwards produces a clean sequence from idx 0.
- Sweep all 504 (N1,N2) pairs × both subframes against the golden model, with back-to-back starts issued in the done cycle.

Source files
------------

// File: rtl/sss_seq_gen.sv
// LTE secondary synchronisation signal generator: latches a cell identity on start,
// derives m0/m1 and streams d(0..61) PAR elements per beat over valid/ready.
module sss_seq_gen #(
  parameter int PAR = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [7:0]     n_id_1,
  input  logic [1:0]     n_id_2,
  input  logic           subframe,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PAR-1:0] out_data,
  output logic [5:0]     out_idx,
  output logic           out_last,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, CALC, STREAM} state_t;

  localparam logic [5:0] STEP     = 6'(PAR);
  localparam logic [5:0] LAST_IDX = 6'(62 - PAR);

  // Bit k of taps selects x(i+k) in the recurrence for x(i+5); seed is x(4)=1.
  function automatic logic [30:0] gen_mseq(input logic [4:0] taps);
    logic [30:0] x;
    x = 31'h10;
    for (int i = 0; i < 26; i++) begin
      x[i+5] = ^(x[i +: 5] & taps);
    end
    return x;
  endfunction

  localparam logic [30:0] X_S = gen_mseq(5'b00101);
  localparam logic [30:0] X_C = gen_mseq(5'b01001);
  localparam logic [30:0] X_Z = gen_mseq(5'b10111);

  function automatic logic [4:0] inc31(input logic [4:0] p);
    return (p == 5'd30) ? 5'd0 : p + 5'd1;
  endfunction

  state_t         state_q, state_d;
  logic [7:0]     n1_q, n1_d;
  logic [1:0]     n2_q, n2_d;
  logic           sf_q, sf_d;
  logic [4:0]     ps0_q, ps0_d, ps1_q, ps1_d;
  logic [4:0]     pc0_q, pc0_d, pc1_q, pc1_d;
  logic [4:0]     pz0_q, pz0_d, pz1_q, pz1_d;
  logic [5:0]     elem_q, elem_d;
  logic           out_valid_q, out_valid_d;
  logic [PAR-1:0] out_data_q, out_data_d;
  logic [5:0]     out_idx_q, out_idx_d;
  logic           out_last_q, out_last_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [8:0]     calc_qp, calc_q, calc_mp, calc_r, calc_t;
  logic [4:0]     calc_m0, calc_m1;
  logic           s0_b, s1_b, c0_b, c1_b, z0_b, z1_b;
  logic           even_bit, odd_bit;
  logic [PAR-1:0] beat_data;
  logic           adv_ptr;
  logic           handshake;

  // m0/m1 from the latched N_ID_1; only consumed in CALC.
  always_comb begin
    calc_qp = {1'b0, n1_q} / 9'd30;
    calc_q  = ({1'b0, n1_q} + ((calc_qp * (calc_qp + 9'd1)) >> 1)) / 9'd30;
    calc_mp = {1'b0, n1_q} + ((calc_q * (calc_q + 9'd1)) >> 1);
    calc_r  = calc_mp % 9'd31;
    calc_t  = (calc_r + (calc_mp / 9'd31) + 9'd1) % 9'd31;
    calc_m0 = calc_r[4:0];
    calc_m1 = calc_t[4:0];
  end

  always_comb begin
    s0_b     = X_S[ps0_q];
    s1_b     = X_S[ps1_q];
    c0_b     = X_C[pc0_q];
    c1_b     = X_C[pc1_q];
    z0_b     = X_Z[pz0_q];
    z1_b     = X_Z[pz1_q];
    even_bit = (sf_q ? s1_b : s0_b) ^ c0_b;
    odd_bit  = (sf_q ? s0_b : s1_b) ^ c1_b ^ (sf_q ? z1_b : z0_b);
  end

  // With PAR=1 the pointers step only after the odd element of each pair.
  if (PAR != 1 && PAR != 2) begin : g_bad_par
    $error("sss_seq_gen: PAR must be 1 or 2");
  end else if (PAR == 2) begin : g_par2
    assign beat_data = {odd_bit, even_bit};
    assign adv_ptr   = 1'b1;
  end else begin : g_par1
    assign beat_data = elem_q[0] ? odd_bit : even_bit;
    assign adv_ptr   = elem_q[0];
  end

  assign handshake = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    n1_d        = n1_q;
    n2_d        = n2_q;
    sf_d        = sf_q;
    ps0_d       = ps0_q;
    ps1_d       = ps1_q;
    pc0_d       = pc0_q;
    pc1_d       = pc1_q;
    pz0_d       = pz0_q;
    pz1_d       = pz1_q;
    elem_d      = elem_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (abort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (n_id_1 <= 8'd167 && n_id_2 != 2'd3) begin
              n1_d    = n_id_1;
              n2_d    = n_id_2;
              sf_d    = subframe;
              state_d = CALC;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        CALC: begin
          ps0_d   = calc_m0;
          ps1_d   = calc_m1;
          pc0_d   = {3'b000, n2_q};
          pc1_d   = {3'b000, n2_q} + 5'd3;
          pz0_d   = {2'b00, calc_m0[2:0]};
          pz1_d   = {2'b00, calc_m1[2:0]};
          elem_d  = 6'd0;
          state_d = STREAM;
        end
        STREAM: begin
          if (handshake && out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else if (!out_valid_q || handshake) begin
            out_valid_d = 1'b1;
            out_data_d  = beat_data;
            out_idx_d   = elem_q;
            out_last_d  = (elem_q == LAST_IDX);
            elem_d      = elem_q + STEP;
            if (adv_ptr) begin
              ps0_d = inc31(ps0_q);
              ps1_d = inc31(ps1_q);
              pc0_d = inc31(pc0_q);
              pc1_d = inc31(pc1_q);
              pz0_d = inc31(pz0_q);
              pz1_d = inc31(pz1_q);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n1_q        <= '0;
      n2_q        <= '0;
      sf_q        <= 1'b0;
      ps0_q       <= '0;
      ps1_q       <= '0;
      pc0_q       <= '0;
      pc1_q       <= '0;
      pz0_q       <= '0;
      pz1_q       <= '0;
      elem_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n1_q        <= n1_d;
      n2_q        <= n2_d;
      sf_q        <= sf_d;
      ps0_q       <= ps0_d;
      ps1_q       <= ps1_d;
      pc0_q       <= pc0_d;
      pc1_q       <= pc1_d;
      pz0_q       <= pz0_d;
      pz1_q       <= pz1_d;
      elem_q      <= elem_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sss_seq_gen.sv
// Scoreboard bench for sss_seq_gen: unit 0 is built with PAR=1, unit 1 with PAR=2.
// Stimulus pushes expected beats from a golden model; a negedge monitor pops and compares.
module tb_sss_seq_gen;

  typedef struct packed {
    logic [1:0] data;
    logic [5:0] idx;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_s[2];
  logic [7:0] n1_s[2];
  logic [1:0] n2_s[2];
  logic       sf_s[2];
  logic       abort_s[2];
  logic       ready_lvl[2];
  logic       stall_en[2];
  logic [1:0] rnd = 2'b00;
  logic       ready_s[2];
  logic       valid_s[2];
  logic [1:0] data_s[2];
  logic [5:0] idx_s[2];
  logic       last_s[2];
  logic       busy_s[2];
  logic       done_s[2];
  logic       err_s[2];
  logic       data0;
  logic [1:0] data1;

  int n_cmp  = 0;
  int n_fail = 0;

  beat_t       sb_q[2][$];
  logic        held[2];
  beat_t       held_b[2];
  logic        done_pend[2];
  logic [61:0] cap0;

  assign ready_s[0] = stall_en[0] ? rnd[0] : ready_lvl[0];
  assign ready_s[1] = stall_en[1] ? rnd[1] : ready_lvl[1];
  assign data_s[0]  = {1'b0, data0};
  assign data_s[1]  = data1;

  always @(posedge clk) begin
    #1;
    rnd = 2'($urandom_range(0, 3));
  end

  sss_seq_gen #(.PAR(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .n_id_1(n1_s[0]), .n_id_2(n2_s[0]),
    .subframe(sf_s[0]), .abort(abort_s[0]), .out_valid(valid_s[0]), .out_ready(ready_s[0]),
    .out_data(data0), .out_idx(idx_s[0]), .out_last(last_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .err(err_s[0])
  );

  sss_seq_gen #(.PAR(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .n_id_1(n1_s[1]), .n_id_2(n2_s[1]),
    .subframe(sf_s[1]), .abort(abort_s[1]), .out_valid(valid_s[1]), .out_ready(ready_s[1]),
    .out_data(data1), .out_idx(idx_s[1]), .out_last(last_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .err(err_s[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Straight from the recurrences and index formulas.
  function automatic logic [61:0] golden(input int n1, input int n2, input int sf);
    int xs[31];
    int xc[31];
    int xz[31];
    int qp, q, mp, m0, m1;
    int s0, s1, c0, c1, z0, z1;
    logic [61:0] d;
    for (int i = 0; i < 4; i++) begin
      xs[i] = 0; xc[i] = 0; xz[i] = 0;
    end
    xs[4] = 1; xc[4] = 1; xz[4] = 1;
    for (int i = 0; i < 26; i++) begin
      xs[i+5] = xs[i+2] ^ xs[i];
      xc[i+5] = xc[i+3] ^ xc[i];
      xz[i+5] = xz[i+4] ^ xz[i+2] ^ xz[i+1] ^ xz[i];
    end
    qp = n1 / 30;
    q  = (n1 + qp * (qp + 1) / 2) / 30;
    mp = n1 + q * (q + 1) / 2;
    m0 = mp % 31;
    m1 = (m0 + mp / 31 + 1) % 31;
    d  = '0;
    for (int n = 0; n < 31; n++) begin
      s0 = xs[(n + m0) % 31];
      s1 = xs[(n + m1) % 31];
      c0 = xc[(n + n2) % 31];
      c1 = xc[(n + n2 + 3) % 31];
      z0 = xz[(n + m0 % 8) % 31];
      z1 = xz[(n + m1 % 8) % 31];
      if (sf == 0) begin
        d[2*n]   = 1'(s0 ^ c0);
        d[2*n+1] = 1'(s1 ^ c1 ^ z0);
      end else begin
        d[2*n]   = 1'(s1 ^ c0);
        d[2*n+1] = 1'(s0 ^ c1 ^ z1);
      end
    end
    return d;
  endfunction

  // Issue one start (expects to be called just after a rising edge); returns at k+#1.
  task automatic applyStimulus(input int u, input int n1, input int n2, input int sf);
    logic [61:0] d;
    beat_t b;
    if (n1 <= 167 && n2 <= 2) begin
      d = golden(n1, n2, sf);
      if (u == 0) begin
        for (int e = 0; e < 62; e++) begin
          b.data = {1'b0, d[e]};
          b.idx  = 6'(e);
          b.last = (e == 61);
          sb_q[0].push_back(b);
        end
      end else begin
        for (int n = 0; n < 31; n++) begin
          b.data = {d[2*n+1], d[2*n]};
          b.idx  = 6'(2 * n);
          b.last = (n == 30);
          sb_q[1].push_back(b);
        end
      end
    end
    start_s[u] = 1'b1;
    n1_s[u]    = 8'(n1);
    n2_s[u]    = 2'(n2);
    sf_s[u]    = 1'(sf);
    @(posedge clk); #1;
    start_s[u] = 1'b0;
    n1_s[u]    = 8'(n1 + 77);
    n2_s[u]    = ~n2_s[u];
    sf_s[u]    = ~sf_s[u];
  endtask

  task automatic waitDone(input int u, input int budget, output int cyc);
    logic got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (done_s[u]) got = 1'b1;
    end
    if (!got) checkOutput("done_timeout", 32'(done_s[u]), 32'd1);
  endtask

  task automatic waitIdx(input int u, input int idx, input int budget);
    logic got;
    int cnt;
    got = 1'b0;
    cnt = 0;
    while (!got && cnt < budget) begin
      if (valid_s[u] && idx_s[u] == 6'(idx)) got = 1'b1;
      else begin
        @(posedge clk); #1;
        cnt++;
      end
    end
    if (!got) checkOutput("idx_timeout", 32'({valid_s[u], idx_s[u]}), 32'({1'b1, 6'(idx)}));
  endtask

  function automatic logic [31:0] allOutputs(input int u);
    return 32'({valid_s[u], data_s[u], idx_s[u], last_s[u], busy_s[u], done_s[u], err_s[u]});
  endfunction

  // Monitor: beats presented with ready high (and no abort) transfer on the next edge.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      beat_t cur;
      beat_t exp;
      cur.data = data_s[u];
      cur.idx  = idx_s[u];
      cur.last = last_s[u];
      if (!rst_n) begin
        held[u]      = 1'b0;
        done_pend[u] = 1'b0;
      end else begin
        if (done_pend[u])
          checkOutput("done_after_last", 32'({busy_s[u], valid_s[u], done_s[u]}), 32'b001);
        else if (done_s[u])
          checkOutput("spurious_done", 32'(done_s[u]), 32'd0);
        done_pend[u] = 1'b0;
        if (held[u] && valid_s[u])
          checkOutput("stall_hold", 32'(cur), 32'(held_b[u]));
        if (valid_s[u] && ready_s[u] && !abort_s[u]) begin
          if (sb_q[u].size() == 0) begin
            checkOutput("beat_expected", 32'(sb_q[u].size()), 32'd1);
          end else begin
            exp = sb_q[u].pop_front();
            checkOutput("beat", 32'(cur), 32'(exp));
            if (u == 0) cap0[idx_s[0]] = data_s[0][0];
            if (exp.last) done_pend[u] = 1'b1;
          end
        end
        held[u]   = valid_s[u] && !ready_s[u] && !abort_s[u];
        held_b[u] = cur;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    cap0 = '0;
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0; n1_s[u] = '0; n2_s[u] = '0; sf_s[u] = 1'b0;
      abort_s[u] = 1'b0; ready_lvl[u] = 1'b0; stall_en[u] = 1'b0;
      held[u] = 1'b0; done_pend[u] = 1'b0; held_b[u] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) checkOutput("reset_state", allOutputs(u), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // N1=0, N2=0, sf=0 on PAR=1: latency, no bubbles, hand-derived first elements.
    $display("[TB] sequence N1=0 N2=0 sf=0 PAR=1");
    ready_lvl[0] = 1'b1;
    applyStimulus(0, 0, 0, 0);
    checkOutput("calc_busy", 32'({busy_s[0], valid_s[0]}), 32'b10);
    @(posedge clk); #1;
    checkOutput("latency_k1", 32'(valid_s[0]), 32'd0);
    @(posedge clk); #1;
    checkOutput("latency_k2", 32'({valid_s[0], idx_s[0]}), 32'({1'b1, 6'd0}));
    waitDone(0, 100, cyc);
    checkOutput("no_bubbles_par1", 32'(cyc), 32'd62);
    checkOutput("hand_d0_10", 32'(cap0[10:0]), 32'h208);
    checkOutput("drain_t1", 32'(sb_q[0].size()), 32'd0);

    // N1=167, N2=2, sf=1 on PAR=2.
    $display("[TB] sequence N1=167 N2=2 sf=1 PAR=2");
    ready_lvl[1] = 1'b1;
    applyStimulus(1, 167, 2, 1);
    waitDone(1, 100, cyc);
    checkOutput("len_par2", 32'(cyc), 32'd33);
    checkOutput("drain_t2", 32'(sb_q[1].size()), 32'd0);

    // N1=30, N2=1, sf=0 with random out_ready stalls.
    $display("[TB] sequence N1=30 N2=1 sf=0 with stalls");
    stall_en[0] = 1'b1;
    applyStimulus(0, 30, 1, 0);
    waitDone(0, 1000, cyc);
    stall_en[0] = 1'b0;
    checkOutput("drain_t3", 32'(sb_q[0].size()), 32'd0);

    // Out-of-range requests.
    $display("[TB] rejected starts");
    applyStimulus(0, 168, 0, 0);
    checkOutput("err_n1", 32'({err_s[0], busy_s[0], valid_s[0]}), 32'b100);
    @(posedge clk); #1;
    checkOutput("err_pulse_n1", 32'({err_s[0], busy_s[0]}), 32'b00);
    applyStimulus(0, 5, 3, 0);
    checkOutput("err_n2", 32'({err_s[0], busy_s[0], valid_s[0]}), 32'b100);
    @(posedge clk); #1;
    checkOutput("err_pulse_n2", 32'({err_s[0], busy_s[0]}), 32'b00);

    // Start during STREAM is ignored; abort at beat 20 beats the handshake.
    $display("[TB] start while busy, abort at beat 20");
    applyStimulus(0, 17, 1, 0);
    waitIdx(0, 5, 20);
    start_s[0] = 1'b1;
    n1_s[0]    = 8'd100;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    checkOutput("start_ignored", 32'({busy_s[0], err_s[0]}), 32'b10);
    waitIdx(0, 20, 40);
    abort_s[0] = 1'b1;
    @(posedge clk); #1;
    abort_s[0] = 1'b0;
    checkOutput("abort_next", 32'({valid_s[0], busy_s[0], done_s[0]}), 32'd0);
    sb_q[0].delete();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_quiet", 32'({valid_s[0], busy_s[0], done_s[0]}), 32'd0);
    applyStimulus(0, 17, 1, 0);
    waitDone(0, 100, cyc);
    checkOutput("post_abort_len", 32'(cyc), 32'd64);
    checkOutput("drain_t5", 32'(sb_q[0].size()), 32'd0);

    // Asynchronous reset mid-stream.
    $display("[TB] reset mid-stream");
    applyStimulus(0, 88, 2, 1);
    waitIdx(0, 10, 30);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", allOutputs(0), 32'd0);
    sb_q[0].delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no_partial", 32'({valid_s[0], busy_s[0]}), 32'd0);
    applyStimulus(0, 88, 2, 1);
    waitDone(0, 100, cyc);
    checkOutput("post_reset_len", 32'(cyc), 32'd64);
    checkOutput("drain_t6", 32'(sb_q[0].size()), 32'd0);

    // Full sweep on PAR=2, each start issued in the previous done cycle.
    $display("[TB] sweep 504 cells x 2 subframes");
    for (int n1 = 0; n1 < 168; n1++) begin
      for (int n2 = 0; n2 < 3; n2++) begin
        for (int sf = 0; sf < 2; sf++) begin
          applyStimulus(1, n1, n2, sf);
          waitDone(1, 100, cyc);
          checkOutput("b2b_len", 32'(cyc), 32'd33);
        end
      end
    end
    @(posedge clk); #1;
    checkOutput("final_drain0", 32'(sb_q[0].size()), 32'd0);
    checkOutput("final_drain1", 32'(sb_q[1].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
